clock_hms_alarm_set: RTL and testbench
======================================

// Module: clock_hms_alarm_set
// PURPOSE
//  24 h real-time clock with button-driven time set, alarm set/compare and 12/24 h display mode.
//  Counts in binary internally; presents BCD hour/minute/second to the 7-segment display driver.
//  Selected field blinks in edit modes (blank code 8'hFF). Buttons are debounced, 1-cycle pulses from upstream.
// PARAMETERS
//  FREQUENCY_IN   100_000_000  clk frequency in Hz; one second = FREQUENCY_IN cycles (>=2)
//  BLINK_HZ       2            blink rate; half-period = FREQUENCY_IN/(2*BLINK_HZ) cycles (integer, >=1)
//  ALARM_SECONDS  30           alarm_out active duration in seconds (1..255)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active-high
//  en_in          in   1  1 = seconds prescaler advances; 0 = time frozen (editing still allowed)
//  mode12_in      in   1  1 = 12 h display, 0 = 24 h display (display only; internal always 24 h)
//  alarm_en_in    in   1  1 = alarm compare armed
//  setupBtn_in    in   1  enter/commit time-set mode
//  alarmBtn_in    in   1  enter/commit alarm-set mode
//  selectBtn_in   in   1  cycle edited field sec->min->hour->sec
//  upBtn_in       in   1  increment edited field
//  downBtn_in     in   1  decrement edited field
//  bcdSecond_out  out  8  BCD seconds (8'hFF when blanked)
//  bcdMinute_out  out  8  BCD minutes (8'hFF when blanked)
//  bcdHour_out    out  8  BCD hours, 24 h or 12 h per mode12_in (8'hFF when blanked)
//  pm_out         out  1  1 = PM in 12 h mode of the displayed hour; 0 in 24 h mode
//  editMode_out   out  2  0 RUN, 1 SET_TIME, 2 SET_ALARM
//  alarm_out      out  1  alarm ringing
// BEHAVIOUR
//  Reset: time, alarm, edit regs = 00:00:00; state RUN; field sel = sec; prescaler, blink = 0;
//   all outputs registered, reset to 8'h00 / 0. Outputs lag internal state by exactly 1 cycle.
//  Prescaler: when en_in, counts 0..FREQUENCY_IN-1; tick on terminal count. Tick advances sec; 59->0 carries
//   min; min 59->0 carries hour; 23:59:59 -> 00:00:00. Time keeps running in all states.
//  Button priority (same cycle): setup > alarm > select > up > down; lower ones ignored.
//  RUN: setup -> SET_TIME, edit regs <= current time (tick in that cycle is lost to snapshot, not to clock).
//   alarm -> SET_ALARM, edit regs <= alarm regs. select/up/down ignored.
//  SET_TIME: setup -> RUN, time <= edit regs, prescaler <= 0. alarm ignored.
//  SET_ALARM: alarm or setup -> RUN, alarm regs <= edit regs.
//  Edit (both set states): select advances field; up/down wrap on edited field only, no carry:
//   sec/min 59<->0, hour 23<->0. Field sel returns to sec on every exit to RUN.
//  Display: RUN shows time; set states show edit regs. Blink phase toggles every half-period, reset to
//   "visible" on entry to a set state; selected field forced to 8'hFF during "blank" half.
//  12 h mapping: hour 0 -> 12 AM; 1..11 -> AM; 12 -> 12 PM; 13..23 -> h-12 PM. Applies in all states.
//  Alarm: in RUN with alarm_en_in=1, when a tick makes time == alarm regs (h,m,s) -> alarm_out=1,
//   countdown = ALARM_SECONDS. Each tick decrements; alarm_out drops when it reaches 0.
//   Any button pulse, alarm_en_in=0, or leaving RUN clears alarm_out next cycle (button still acts).
//   No trigger from set-commit or from time loaded equal to alarm; only via tick.
//  rst mid-edit discards edit regs; mid-alarm clears alarm_out.
// TESTING (FREQUENCY_IN=10, BLINK_HZ=1, ALARM_SECONDS=3)
//  1 rst, en_in=1, run 600 cycles -> bcdMinute_out=8'h01, bcdSecond_out=8'h00; 10 cycles/second exact.
//  2 set time 23:59:58 via setup/select/down, commit, 20 cycles -> 00:00:00, then continues 00:00:01.
//  3 in SET_TIME sec field: down at 0 -> 59; up at 59 -> 0, minute unchanged; hour up at 23 -> 0.
//  4 alarm 00:00:05, alarm_en_in=1, from rst -> alarm_out rises cycle after 5th tick, falls after 3 ticks;
//    repeat with upBtn pulse while ringing -> alarm_out low next cycle.
//  5 mode12_in=1, hours 0/12/13 -> bcdHour_out 8'h12 pm 0 / 8'h12 pm 1 / 8'h01 pm 1.
//  6 in SET_ALARM minute field -> bcdMinute_out alternates value/8'hFF every 5 cycles; setup+up same cycle
//    -> commit only, value unchanged; rst mid-edit -> RUN, 00:00:00, editMode_out=0.

Source files
------------

// File: rtl/clock_hms_alarm_set.sv
// 24 h real-time clock with button-driven time/alarm setting, blinking edit field,
// alarm compare with timed ringing, and registered BCD display in 12 h or 24 h form.
module clock_hms_alarm_set #(
  parameter int unsigned FREQUENCY_IN  = 100_000_000,
  parameter int unsigned BLINK_HZ      = 2,
  parameter int unsigned ALARM_SECONDS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_in,
  input  logic       mode12_in,
  input  logic       alarm_en_in,
  input  logic       setupBtn_in,
  input  logic       alarmBtn_in,
  input  logic       selectBtn_in,
  input  logic       upBtn_in,
  input  logic       downBtn_in,
  output logic [7:0] bcdSecond_out,
  output logic [7:0] bcdMinute_out,
  output logic [7:0] bcdHour_out,
  output logic       pm_out,
  output logic [1:0] editMode_out,
  output logic       alarm_out
);
  localparam int unsigned HALF_BLINK = FREQUENCY_IN / (2 * BLINK_HZ);
  localparam int unsigned PW = $clog2(FREQUENCY_IN);
  localparam int unsigned BW = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;

  typedef enum logic [1:0] {RUN = 2'd0, SET_TIME = 2'd1, SET_ALARM = 2'd2} mode_t;
  typedef enum logic [1:0] {F_SEC = 2'd0, F_MIN = 2'd1, F_HOUR = 2'd2} field_t;

  mode_t         state;
  field_t        field, fieldE;
  logic [PW-1:0] presc;
  logic [BW-1:0] blinkCnt;
  logic          blank;
  logic [7:0]    alarmCnt;
  logic [5:0]    curSec, curMin, alSec, alMin, edSec, edMin;
  logic [4:0]    curHour, alHour, edHour;
  logic [5:0]    nxtSec, nxtMin, edSecE, edMinE, dispSec, dispMin;
  logic [4:0]    nxtHour, edHourE, dispHour, showHour;
  logic          tick, secWrap, minWrap, hourWrap;
  logic          btnSetup, btnAlarm, btnSel, btnUp, btnDown, anyBtn, enterSet;
  logic          pmN;
  logic [7:0]    secN, minN, hourN;

  function automatic logic [7:0] toBcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  assign tick     = en_in && (presc == PW'(FREQUENCY_IN - 1));
  assign secWrap  = (curSec == 6'd59);
  assign minWrap  = (curMin == 6'd59);
  assign hourWrap = (curHour == 5'd23);
  assign nxtSec   = secWrap ? '0 : curSec + 6'd1;
  assign nxtMin   = !secWrap ? curMin : (minWrap ? '0 : curMin + 6'd1);
  assign nxtHour  = !(secWrap && minWrap) ? curHour : (hourWrap ? '0 : curHour + 5'd1);

  // Only the highest-priority pulse in a cycle is acted upon.
  assign btnSetup = setupBtn_in;
  assign btnAlarm = !setupBtn_in && alarmBtn_in;
  assign btnSel   = !setupBtn_in && !alarmBtn_in && selectBtn_in;
  assign btnUp    = !setupBtn_in && !alarmBtn_in && !selectBtn_in && upBtn_in;
  assign btnDown  = !setupBtn_in && !alarmBtn_in && !selectBtn_in && !upBtn_in && downBtn_in;
  assign anyBtn   = setupBtn_in || alarmBtn_in || selectBtn_in || upBtn_in || downBtn_in;
  assign enterSet = (state == RUN) && (btnSetup || btnAlarm);

  always_comb begin
    edSecE  = edSec;
    edMinE  = edMin;
    edHourE = edHour;
    fieldE  = field;
    if (btnSel) begin
      case (field)
        F_SEC:   fieldE = F_MIN;
        F_MIN:   fieldE = F_HOUR;
        default: fieldE = F_SEC;
      endcase
    end else if (btnUp) begin
      case (field)
        F_SEC:   edSecE  = (edSec == 6'd59) ? '0 : edSec + 6'd1;
        F_MIN:   edMinE  = (edMin == 6'd59) ? '0 : edMin + 6'd1;
        default: edHourE = (edHour == 5'd23) ? '0 : edHour + 5'd1;
      endcase
    end else if (btnDown) begin
      case (field)
        F_SEC:   edSecE  = (edSec == '0) ? 6'd59 : edSec - 6'd1;
        F_MIN:   edMinE  = (edMin == '0) ? 6'd59 : edMin - 6'd1;
        default: edHourE = (edHour == '0) ? 5'd23 : edHour - 5'd1;
      endcase
    end
  end

  always_comb begin
    if (state == RUN) begin
      dispSec  = curSec;
      dispMin  = curMin;
      dispHour = curHour;
    end else begin
      dispSec  = edSec;
      dispMin  = edMin;
      dispHour = edHour;
    end
    showHour = dispHour;
    pmN      = 1'b0;
    if (mode12_in) begin
      pmN = (dispHour >= 5'd12);
      if (dispHour == '0)         showHour = 5'd12;
      else if (dispHour > 5'd12)  showHour = dispHour - 5'd12;
    end
    secN  = toBcd(dispSec);
    minN  = toBcd(dispMin);
    hourN = toBcd({1'b0, showHour});
    if (state != RUN && blank) begin
      case (field)
        F_SEC:   secN  = 8'hFF;
        F_MIN:   minN  = 8'hFF;
        default: hourN = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      field    <= F_SEC;
      presc    <= '0;
      blinkCnt <= '0;
      blank    <= 1'b0;
      alarmCnt <= '0;
      curSec   <= '0;  curMin <= '0;  curHour <= '0;
      alSec    <= '0;  alMin  <= '0;  alHour  <= '0;
      edSec    <= '0;  edMin  <= '0;  edHour  <= '0;
      bcdSecond_out <= '0;
      bcdMinute_out <= '0;
      bcdHour_out   <= '0;
      pm_out        <= 1'b0;
      editMode_out  <= '0;
      alarm_out     <= 1'b0;
    end else begin
      if (en_in) presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        curSec  <= nxtSec;
        curMin  <= nxtMin;
        curHour <= nxtHour;
      end

      if (enterSet) begin
        blinkCnt <= '0;
        blank    <= 1'b0;
      end else if (blinkCnt == BW'(HALF_BLINK - 1)) begin
        blinkCnt <= '0;
        blank    <= ~blank;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end

      // Ringing is a non-zero countdown; any interaction or leaving RUN silences it.
      if (anyBtn || !alarm_en_in || state != RUN)
        alarmCnt <= '0;
      else if (tick && {nxtHour, nxtMin, nxtSec} == {alHour, alMin, alSec})
        alarmCnt <= 8'(ALARM_SECONDS);
      else if (tick && alarmCnt != '0)
        alarmCnt <= alarmCnt - 8'd1;

      // Commit writes below override the tick update above for the same cycle.
      case (state)
        RUN: begin
          if (btnSetup) begin
            state  <= SET_TIME;
            edSec  <= curSec;  edMin <= curMin;  edHour <= curHour;
          end else if (btnAlarm) begin
            state  <= SET_ALARM;
            edSec  <= alSec;   edMin <= alMin;   edHour <= alHour;
          end
        end
        SET_TIME: begin
          if (btnSetup) begin
            state   <= RUN;
            field   <= F_SEC;
            curSec  <= edSec;  curMin <= edMin;  curHour <= edHour;
            presc   <= '0;
          end else begin
            field  <= fieldE;
            edSec  <= edSecE;  edMin <= edMinE;  edHour <= edHourE;
          end
        end
        SET_ALARM: begin
          if (btnSetup || btnAlarm) begin
            state  <= RUN;
            field  <= F_SEC;
            alSec  <= edSec;   alMin <= edMin;   alHour <= edHour;
          end else begin
            field  <= fieldE;
            edSec  <= edSecE;  edMin <= edMinE;  edHour <= edHourE;
          end
        end
        default: state <= RUN;
      endcase

      bcdSecond_out <= secN;
      bcdMinute_out <= minN;
      bcdHour_out   <= hourN;
      pm_out        <= pmN;
      editMode_out  <= state;
      alarm_out     <= (alarmCnt != '0);
    end
  end
endmodule

// File: tb/tb_clock_hms_alarm_set.sv
// Scoreboard bench: a seconds-of-day reference model queues the expected registered outputs
// per cycle; a monitor compares them one cycle later.
module tb_clock_hms_alarm_set;
  localparam int F    = 10;
  localparam int BH   = 1;
  localparam int AS   = 3;
  localparam int HALF = F / (2 * BH);
  localparam logic [4:0] B_SET = 5'b10000, B_AL = 5'b01000, B_SEL = 5'b00100,
                         B_UP  = 5'b00010, B_DN = 5'b00001;

  logic clk = 1'b0, rst = 1'b0, en_in = 1'b0, mode12_in = 1'b0, alarm_en_in = 1'b0;
  logic setupBtn_in = 1'b0, alarmBtn_in = 1'b0, selectBtn_in = 1'b0, upBtn_in = 1'b0, downBtn_in = 1'b0;
  logic [7:0] bcdSecond_out, bcdMinute_out, bcdHour_out;
  logic       pm_out, alarm_out;
  logic [1:0] editMode_out;

  clock_hms_alarm_set #(.FREQUENCY_IN(F), .BLINK_HZ(BH), .ALARM_SECONDS(AS)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .mode12_in(mode12_in), .alarm_en_in(alarm_en_in),
    .setupBtn_in(setupBtn_in), .alarmBtn_in(alarmBtn_in), .selectBtn_in(selectBtn_in),
    .upBtn_in(upBtn_in), .downBtn_in(downBtn_in),
    .bcdSecond_out(bcdSecond_out), .bcdMinute_out(bcdMinute_out), .bcdHour_out(bcdHour_out),
    .pm_out(pm_out), .editMode_out(editMode_out), .alarm_out(alarm_out));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] s, m, h;
    logic       pm;
    logic [1:0] mode;
    logic       al;
  } obs_t;

  obs_t expQ[$];
  int tests = 0, fails = 0, monCyc = 0;
  bit lvEn = 0, lvM12 = 0, lvAlEn = 0;

  // Reference model: times held as seconds-of-day, edit fields as plain integers.
  int mState = 0, tod = 0, alarmTod = 0, eH = 0, eM = 0, eS = 0, fieldIdx = 0;
  int enCycles = 0, blinkAge = 0, ring = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic obs_t expected();
    obs_t e;
    int h, m, s, hh;
    bit blk;
    if (mState == 0) begin
      h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
    end else begin
      h = eH; m = eM; s = eS;
    end
    blk  = (mState != 0) && (((blinkAge / HALF) % 2) == 1);
    hh   = h;
    e.pm = 1'b0;
    if (lvM12) begin
      hh   = (h % 12 == 0) ? 12 : h % 12;
      e.pm = (h >= 12);
    end
    e.s    = (blk && fieldIdx == 0) ? 8'hFF : bcd(s);
    e.m    = (blk && fieldIdx == 1) ? 8'hFF : bcd(m);
    e.h    = (blk && fieldIdx == 2) ? 8'hFF : bcd(hh);
    e.mode = 2'(mState);
    e.al   = (ring > 0);
    return e;
  endfunction

  task automatic editField(input int btn);
    if (btn == 3) fieldIdx = (fieldIdx + 1) % 3;
    else if (btn == 4) begin
      if (fieldIdx == 0) eS = (eS + 1) % 60;
      else if (fieldIdx == 1) eM = (eM + 1) % 60;
      else eH = (eH + 1) % 24;
    end else if (btn == 5) begin
      if (fieldIdx == 0) eS = (eS + 59) % 60;
      else if (fieldIdx == 1) eM = (eM + 59) % 60;
      else eH = (eH + 23) % 24;
    end
  endtask

  task automatic modelUpdate(input bit doRst, input logic [4:0] btns);
    int btn, prevTod, nextTod;
    bit tick;
    if (doRst) begin
      mState = 0; tod = 0; alarmTod = 0; eH = 0; eM = 0; eS = 0; fieldIdx = 0;
      enCycles = 0; blinkAge = 0; ring = 0;
    end else begin
      btn = btns[4] ? 1 : btns[3] ? 2 : btns[2] ? 3 : btns[1] ? 4 : btns[0] ? 5 : 0;
      tick = lvEn && (enCycles == F - 1);
      if (lvEn) enCycles = tick ? 0 : enCycles + 1;
      prevTod = tod;
      nextTod = tick ? (tod + 1) % 86400 : tod;
      if (btn != 0 || !lvAlEn || mState != 0) ring = 0;
      else if (tick) begin
        if (nextTod == alarmTod) ring = AS;
        else if (ring > 0) ring--;
      end
      if (mState != 0) blinkAge++;
      tod = nextTod;
      case (mState)
        0: begin
          if (btn == 1) begin
            mState = 1; blinkAge = 0;
            eH = prevTod / 3600; eM = (prevTod / 60) % 60; eS = prevTod % 60;
          end else if (btn == 2) begin
            mState = 2; blinkAge = 0;
            eH = alarmTod / 3600; eM = (alarmTod / 60) % 60; eS = alarmTod % 60;
          end
        end
        1: begin
          if (btn == 1) begin
            tod = eH * 3600 + eM * 60 + eS; enCycles = 0; mState = 0; fieldIdx = 0;
          end else if (btn != 2) editField(btn);
        end
        default: begin
          if (btn == 1 || btn == 2) begin
            alarmTod = eH * 3600 + eM * 60 + eS; mState = 0; fieldIdx = 0;
          end else editField(btn);
        end
      endcase
    end
  endtask

  task automatic step(input logic [4:0] btns, input bit doRst);
    @(negedge clk);
    rst = doRst; en_in = lvEn; mode12_in = lvM12; alarm_en_in = lvAlEn;
    {setupBtn_in, alarmBtn_in, selectBtn_in, upBtn_in, downBtn_in} = btns;
    expQ.push_back(doRst ? obs_t'(0) : expected());
    modelUpdate(doRst, btns);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(5'b0, 1'b0);
  endtask

  task automatic press(input logic [4:0] b, input int unsigned n);
    repeat (n) begin
      step(b, 1'b0);
      step(5'b0, 1'b0);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, monCyc, act, req);
    end
  endtask

  always @(posedge clk) begin
    obs_t e;
    #1;
    monCyc++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("bcdSecond", bcdSecond_out, e.s);
      chk("bcdMinute", bcdMinute_out, e.m);
      chk("bcdHour",   bcdHour_out,   e.h);
      chk("pm",        {7'd0, pm_out},    {7'd0, e.pm});
      chk("editMode",  {6'd0, editMode_out}, {6'd0, e.mode});
      chk("alarm",     {7'd0, alarm_out}, {7'd0, e.al});
    end
  end

  initial begin
    logic [4:0] b;
    step(5'b0, 1'b1);
    step(5'b0, 1'b1);
    // One minute of free running.
    lvEn = 1;
    idle(600);
    // Set 23:59:58 and watch midnight roll over.
    press(B_SET, 1); press(B_DN, 2); press(B_SEL, 1); press(B_DN, 2);
    press(B_SEL, 1); press(B_DN, 1);
    step(B_SET, 1'b0);
    idle(40);
    // Field wrap in SET_TIME with time frozen.
    step(5'b0, 1'b1);
    lvEn = 0;
    press(B_SET, 1); press(B_DN, 1); press(B_UP, 1); press(B_SEL, 2);
    press(B_DN, 1); press(B_UP, 1); press(B_SET, 1);
    // Alarm at 00:00:05 rings for three seconds.
    step(5'b0, 1'b1);
    press(B_AL, 1); press(B_UP, 5); press(B_AL, 1);
    lvEn = 1; lvAlEn = 1;
    idle(100);
    // Re-arm at 00:00:15 and silence it with a button while ringing.
    press(B_AL, 1); press(B_UP, 10); press(B_AL, 1);
    for (int unsigned i = 0; i < 400 && ring == 0; i++) idle(1);
    if (ring == 0) begin
      tests++; fails++;
      $display("FAIL alarm_wait: got no ring expected ring within 400 cycles");
    end
    idle(3);
    step(B_UP, 1'b0);
    idle(20);
    // 12 h display of hours 0, 12, 13.
    step(5'b0, 1'b1);
    lvEn = 0; lvAlEn = 0; lvM12 = 1;
    idle(3);
    press(B_SET, 1); press(B_SEL, 2); press(B_UP, 12); press(B_SET, 1);
    idle(3);
    press(B_SET, 1); press(B_SEL, 2); press(B_UP, 1); press(B_SET, 1);
    idle(3);
    lvM12 = 0;
    // Minute field blinking in SET_ALARM, setup+up commits only, rst mid-edit.
    press(B_AL, 1); press(B_SEL, 1);
    idle(22);
    step(B_SET | B_UP, 1'b0);
    idle(3);
    press(B_AL, 1); press(B_UP, 3);
    step(5'b0, 1'b1);
    idle(5);
    // Randomized traffic.
    lvEn = 1;
    for (int unsigned i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) lvEn = ~lvEn;
      if ($urandom_range(0, 99) == 0) lvM12 = ~lvM12;
      if ($urandom_range(0, 99) == 0) lvAlEn = ~lvAlEn;
      b = 5'b0;
      if ($urandom_range(0, 99) < 8) b = 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 99) < 2) b = b | 5'(1 << $urandom_range(0, 4));
      step(b, $urandom_range(0, 999) == 0);
    end
    step(5'b0, 1'b0);
    @(posedge clk);
    #3;
    if (expQ.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
